// File: rtl/caseg_scan_decoder.sv
// caseg_scan_decoder
// Receive side of a multiplexed 8-digit common-anode seven-segment bus.
// The block samples the scanned bus and waits for each digit dwell to settle.
// It then decodes the glyph back to a 4-bit code and reassembles the eight
// digits into a frame.
//
// Ports:
//   sclk        system clock (50 MHz)
//   nrst        synchronous active-low reset
//   sel[7:0]    one-hot digit select, bit7 = leftmost digit
//   seg[7:0]    active-low segments, bit7 = DP ... bit0 = A
//   dig_7..0    last complete decoded frame, dig_7 leftmost
//   frame_done  one-cycle pulse when dig_* update
//   seg_err     one-cycle pulse when an undecodable glyph is captured
//   link_ok     high while frames keep arriving within TIMEOUT_CYC
module caseg_scan_decoder #(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic [3:0] dig_7,
    output logic [3:0] dig_6,
    output logic [3:0] dig_5,
    output logic [3:0] dig_4,
    output logic [3:0] dig_3,
    output logic [3:0] dig_2,
    output logic [3:0] dig_1,
    output logic [3:0] dig_0,
    output logic       frame_done,
    output logic       seg_err,
    output logic       link_ok
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
    localparam logic [SW-1:0] STAB_ARM = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    // Returns {valid, code}. Any glyph with DP lit falls through to invalid.
    function automatic logic [4:0] f_decode(input logic [7:0] g);
        logic [4:0] r;
        case (g)
            8'hC0:   r = 5'h10;
            8'hF9:   r = 5'h11;
            8'hA4:   r = 5'h12;
            8'hB0:   r = 5'h13;
            8'h99:   r = 5'h14;
            8'h92:   r = 5'h15;
            8'h82:   r = 5'h16;
            8'hF8:   r = 5'h17;
            8'h80:   r = 5'h18;
            8'h90:   r = 5'h19;
            8'hFF:   r = 5'h1A;
            8'hBF:   r = 5'h1B;
            8'hC6:   r = 5'h1C;
            8'h89:   r = 5'h1D;
            8'hC7:   r = 5'h1E;
            8'h8C:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] f_slot(input logic [7:0] s);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) r = 3'(i);
        end
        return r;
    endfunction

    logic [7:0]    r_sel_q, r_seg_q, r_prev_sel, r_prev_seg;
    logic [SW-1:0] r_stab_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_mask;
    logic [3:0]    r_shadow [8];
    logic [3:0]    r_dig    [8];
    logic          r_frame_done, r_seg_err, r_link_ok;

    logic       w_onehot, w_same, w_strobe, w_legal, w_complete;
    logic [4:0] w_dec;
    logic [3:0] w_code;
    logic [2:0] w_slot;
    logic [7:0] w_mask_nxt;

    assign w_onehot   = (r_sel_q != 8'd0) && ((r_sel_q & (r_sel_q - 8'd1)) == 8'd0);
    assign w_same     = (r_sel_q == r_prev_sel) && (r_seg_q == r_prev_seg);
    // Fires only on the STABLE_CYC-1 -> STABLE_CYC step, so a saturated dwell
    // never captures twice.
    assign w_strobe   = w_onehot && w_same && (r_stab_cnt == STAB_ARM);
    assign w_dec      = f_decode(r_seg_q);
    assign w_legal    = w_dec[4];
    assign w_code     = w_dec[3:0];
    assign w_slot     = f_slot(r_sel_q);
    assign w_mask_nxt = r_mask | r_sel_q;
    assign w_complete = w_strobe && w_legal && (&w_mask_nxt);

    always_ff @(posedge sclk) begin
        if (!nrst) begin
            r_sel_q      <= '0;
            r_seg_q      <= '0;
            r_prev_sel   <= '0;
            r_prev_seg   <= '0;
            r_stab_cnt   <= '0;
            r_to_cnt     <= '0;
            r_mask       <= '0;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_link_ok    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= '0;
                r_dig[i]    <= '0;
            end
        end else begin
            r_sel_q      <= sel;
            r_seg_q      <= seg;
            r_prev_sel   <= r_sel_q;
            r_prev_seg   <= r_seg_q;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;

            if (!w_onehot || !w_same)
                r_stab_cnt <= '0;
            else if (r_stab_cnt != STAB_MAX)
                r_stab_cnt <= r_stab_cnt + SW'(1);

            if (w_strobe) begin
                if (!w_legal) begin
                    r_seg_err <= 1'b1;
                end else if (w_complete) begin
                    // Publish shadow merged with the digit being captured now.
                    for (int i = 0; i < 8; i++)
                        r_dig[i] <= (3'(i) == w_slot) ? w_code : r_shadow[i];
                    r_shadow[w_slot] <= w_code;
                    r_mask           <= '0;
                    r_frame_done     <= 1'b1;
                end else begin
                    r_shadow[w_slot] <= w_code;
                    r_mask           <= w_mask_nxt;
                end
            end

            if (w_complete) begin
                r_to_cnt  <= '0;
                r_link_ok <= 1'b1;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TW'(1);
                if (r_to_cnt == TO_LAST) r_link_ok <= 1'b0;
            end
        end
    end

    assign dig_7      = r_dig[7];
    assign dig_6      = r_dig[6];
    assign dig_5      = r_dig[5];
    assign dig_4      = r_dig[4];
    assign dig_3      = r_dig[3];
    assign dig_2      = r_dig[2];
    assign dig_1      = r_dig[1];
    assign dig_0      = r_dig[0];
    assign frame_done = r_frame_done;
    assign seg_err    = r_seg_err;
    assign link_ok    = r_link_ok;

endmodule

// File: tb/tb_caseg_scan_decoder.sv
// Directed bench for caseg_scan_decoder with STABLE_CYC=4, TIMEOUT_CYC=200.
module tb_caseg_scan_decoder;

    logic       sclk = 1'b0;
    logic       nrst;
    logic [7:0] sel, seg;
    logic [3:0] dig_7, dig_6, dig_5, dig_4, dig_3, dig_2, dig_1, dig_0;
    logic       frame_done, seg_err, link_ok;

    int n_chk  = 0;
    int n_fail = 0;
    int n_fd   = 0;
    int n_err  = 0;
    int fd0, err0;

    logic [7:0] enc [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'hFF, 8'hBF, 8'hC6, 8'h89, 8'hC7, 8'h8C};

    wire [31:0] w_dig = {dig_7, dig_6, dig_5, dig_4, dig_3, dig_2, dig_1, dig_0};

    caseg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(200)) dut (
        .sclk(sclk), .nrst(nrst), .sel(sel), .seg(seg),
        .dig_7(dig_7), .dig_6(dig_6), .dig_5(dig_5), .dig_4(dig_4),
        .dig_3(dig_3), .dig_2(dig_2), .dig_1(dig_1), .dig_0(dig_0),
        .frame_done(frame_done), .seg_err(seg_err), .link_ok(link_ok)
    );

    always #10 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (frame_done === 1'b1) n_fd++;
        if (seg_err === 1'b1) n_err++;
        if (frame_done === 1'b1 && seg_err === 1'b1) chk("fd_err_coincide", 1, 0);
    end

    task automatic drive(input logic [7:0] s, input logic [7:0] g);
        @(negedge sclk);
        sel = s;
        seg = g;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sclk);
    endtask

    task automatic dwell(input logic [7:0] s, input logic [7:0] g, input int n);
        drive(s, g);
        wait_cyc(n);
    endtask

    // Scan slots hi down to lo; slot s shows nibble s of digs.
    task automatic scan_slots(input logic [31:0] digs, input int hi, input int lo, input int n);
        for (int s = hi; s >= lo; s--)
            dwell(8'(1 << s), enc[digs[4*s +: 4]], n);
    endtask

    initial begin
        nrst = 1'b0;
        sel  = 8'h00;
        seg  = 8'hFF;
        wait_cyc(3);
        #1;
        chk("rst_dig", w_dig, 32'h0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", seg_err, 0);
        chk("rst_link", link_ok, 0);
        @(negedge sclk);
        nrst = 1'b1;

        // Full frame 1..8 with 20-cycle dwells; frame_done at exactly dwell+5.
        scan_slots(32'h12345678, 7, 1, 20);
        chk("f1_no_early_fd", n_fd, 0);
        drive(8'h01, enc[8]);
        wait_cyc(5); #1;
        chk("f1_fd_before", frame_done, 0);
        wait_cyc(1); #1;
        chk("f1_fd_pulse", frame_done, 1);
        chk("f1_dig", w_dig, 32'h12345678);
        chk("f1_link", link_ok, 1);
        wait_cyc(1); #1;
        chk("f1_fd_one_cycle", frame_done, 0);
        wait_cyc(13);
        chk("f1_fd_count", n_fd, 1);
        chk("f1_no_err", n_err, 0);

        // Short dwell on slot 2 must not capture, a longer one must.
        scan_slots(32'h0, 7, 3, 12);
        dwell(8'h04, 8'hC6, 3);
        scan_slots(32'h0, 1, 0, 12);
        chk("short_no_frame", n_fd, 1);
        chk("short_dig_hold", w_dig, 32'h12345678);
        dwell(8'h04, 8'hC6, 10);
        chk("long_frame", n_fd, 2);
        chk("long_dig", w_dig, 32'h00000C00);

        // Illegal glyphs on slot 5: one error per dwell, mask untouched.
        err0 = n_err;
        fd0  = n_fd;
        drive(8'h20, 8'h7F);
        wait_cyc(5); #1;
        chk("ill_err_before", seg_err, 0);
        wait_cyc(1); #1;
        chk("ill_err_pulse", seg_err, 1);
        wait_cyc(1); #1;
        chk("ill_err_one_cycle", seg_err, 0);
        wait_cyc(23);
        dwell(8'h20, 8'h12, 30);
        chk("ill_err_count", n_err, err0 + 2);
        chk("ill_dig_hold", w_dig, 32'h00000C00);
        scan_slots(32'h87654321, 7, 6, 10);
        scan_slots(32'h87654321, 4, 0, 10);
        chk("ill_slot5_not_masked", n_fd, fd0);
        dwell(8'h20, enc[6], 10);
        chk("ill_then_frame", n_fd, fd0 + 1);
        chk("ill_frame_dig", w_dig, 32'h87654321);

        // Multi-hot and zero select never capture, even with an illegal glyph.
        err0 = n_err;
        fd0  = n_fd;
        dwell(8'h03, 8'h12, 100);
        dwell(8'h00, 8'h12, 100);
        chk("mh_no_err", n_err, err0);
        chk("mh_no_fd", n_fd, fd0);
        drive(8'h08, 8'h12);
        wait_cyc(5); #1;
        chk("resume_before", seg_err, 0);
        wait_cyc(1); #1;
        chk("resume_capture", seg_err, 1);
        wait_cyc(4);

        // Timeout: link already down, frame raises it on the same edge.
        chk("to_link_down", link_ok, 0);
        scan_slots(32'h2468ACE0, 7, 1, 10);
        drive(8'h01, enc[0]);
        wait_cyc(5); #1;
        chk("to_link_pre", link_ok, 0);
        wait_cyc(1); #1;
        chk("to_fd", frame_done, 1);
        chk("to_link_up", link_ok, 1);
        chk("to_dig", w_dig, 32'h2468ACE0);
        wait_cyc(199); #1;
        chk("to_link_199", link_ok, 1);
        wait_cyc(1); #1;
        chk("to_link_200", link_ok, 0);

        // Reset mid-frame discards slots 4..0.
        scan_slots(32'h00054321, 4, 0, 10);
        @(negedge sclk);
        nrst = 1'b0;
        sel  = 8'h00;
        seg  = 8'hFF;
        wait_cyc(3); #1;
        chk("mid_rst_dig", w_dig, 32'h0);
        chk("mid_rst_link", link_ok, 0);
        @(negedge sclk);
        nrst = 1'b1;
        fd0  = n_fd;
        err0 = n_err;
        scan_slots(32'hABCDEF09, 7, 1, 10);
        chk("mid_no_stale_fd", n_fd, fd0);
        chk("mid_dig_zero", w_dig, 32'h0);
        dwell(8'h01, enc[9], 10);
        chk("mid_one_fd", n_fd, fd0 + 1);
        chk("mid_dig", w_dig, 32'hABCDEF09);
        chk("mid_no_err", n_err, err0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/caseg_scan_decoder.md
Name: caseg_scan_decoder

Overview:
- Receive side of the multiplexed 8-digit common-anode seven-segment bus (sel one-hot digit select, seg active-low DP,G,F,E,D,C,B,A).
- Samples the scanned bus, waits for each digit dwell to settle, and decodes the glyph back to its 4-bit digit code.
- Reassembles all eight digits into a frame and flags frame completion, illegal glyphs and loss of scan activity.
- Used as a loopback checker and display monitor alongside the display driver, in the same 50 MHz domain.

Parameters:
- STABLE_CYC, 16, consecutive cycles the registered (sel,seg) pair must be unchanged before capture; legal range 2..65535.
- TIMEOUT_CYC, 500000, cycles without a completed frame before link_ok drops (10 ms at 50 MHz; the nominal frame is 8 ms).

Ports:
- sclk  input  1  system clock, 50 MHz
- nrst  input  1  synchronous active-low reset
- sel  input  8  digit select, one-hot, bit7 = DIG_7 (leftmost)
- seg  input  8  segment lines, active low, bit7 = DP ... bit0 = A
- dig_7 .. dig_0  output  4 each  last complete decoded frame, dig_7 leftmost
- frame_done  output  1  one-cycle pulse when dig_7..dig_0 update
- seg_err  output  1  one-cycle pulse on capture of an undecodable glyph
- link_ok  output  1  high while frames arrive within TIMEOUT_CYC

Behaviour:
- Reset: nrst sampled low at a sclk edge clears all state. On that edge, dig_* = 0, frame_done = 0, seg_err = 0, link_ok = 0, the capture mask is cleared, and the stability and timeout counters are cleared.
- Input stage: sel and seg are registered once into sel_q and seg_q. prev_q holds the prior (sel_q,seg_q) pair.
- Stability counter stab_cnt:
  - Cleared when sel_q is not one-hot (zero or multi-hot).
  - Cleared when (sel_q,seg_q) differs from prev_q.
  - Otherwise increments, saturating at STABLE_CYC.
  - Capture strobe fires in the cycle stab_cnt goes from STABLE_CYC-1 to STABLE_CYC. It fires exactly once per dwell. A new dwell needs a change or an illegal sel first.
- Decode of seg_q at capture (any value not listed is illegal):
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7
  - 80→8, 90→9, FF→A (blank), BF→B (dash), C6→C, 89→D, C7→E, 8C→F
  - Any pattern with DP low (seg[7]=0) is illegal.
- Legal capture:
  - Slot index = position of the set bit in sel_q.
  - Writes the shadow digit for that slot and sets that slot's mask bit.
  - Recapturing an already-masked slot overwrites the shadow value and leaves the mask unchanged.
- Illegal capture: seg_err pulses for 1 cycle on the edge after the strobe. Shadow and mask are unchanged.
- Frame completion:
  - Occurs on the edge where a legal capture makes the mask all ones.
  - On that edge, dig_* load the shadow merged with the newly captured digit, frame_done pulses for 1 cycle, and the mask clears.
  - dig_* hold between frames.
- Latency: capture happens STABLE_CYC+1 cycles after a change on the pins, excluding prior dwell effects.
- Timeout counter:
  - Increments every cycle, saturating at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC, link_ok goes 0.
  - frame_done clears the counter and sets link_ok = 1 on the same edge.
- Reset mid-frame discards the partial mask and shadow. dig_* return to 0.
- frame_done and seg_err cannot coincide, because an illegal capture never completes a frame.

Test Plan:
- STABLE_CYC=4. Scan digits 1,2,3,4,5,6,7,8 (dig_7..dig_0) with a 20-cycle dwell per digit → after the 8th dwell + 5 cycles: frame_done one pulse, dig_7=1 ... dig_0=8, link_ok=1, seg_err never asserted.
- Hold sel=0000_0100, seg=0xC6 with a 3-cycle dwell (shorter than STABLE_CYC) → no capture, mask unchanged. Extend the dwell to 10 cycles → slot 2 captures digit C exactly once.
- Drive seg=0x7F (DP low) and then seg=0x12 on slot 5 → seg_err pulses once per dwell, no frame completes, dig_* unchanged.
- sel=0000_0011 (multi-hot) or sel=0 for 100 cycles → no captures and no errors. The stability counter restarts when a legal one-hot sel resumes.
- TIMEOUT_CYC=200, stop scanning after one frame → link_ok falls 200 cycles after frame_done. The next completed frame raises link_ok on the same edge as frame_done.
- Assert nrst low after 5 of 8 slots are captured, then release and scan a full frame of A,B,C,D,E,F,0,9 → dig_* = 0 during reset. One frame_done after the full 8 new dwells, with no stale slots carried over.
